// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg: shared state encoding and widths for MAC sequencing controllers
package mac_seq_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int ACC_WIDTH      = 2 * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  function automatic int acc_width(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: streams N operand pairs into an external MAC and returns the dot product
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [LEN_WIDTH-1:0]          cmd_len,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [DATA_WIDTH-1:0]         op_a,
  input  logic [DATA_WIDTH-1:0]         op_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [2*DATA_WIDTH-1:0]       res_data,
  output logic                          busy,
  output logic                          mac_rst,
  output logic [DATA_WIDTH-1:0]         mac_a,
  output logic [DATA_WIDTH-1:0]         mac_b,
  output logic [2*DATA_WIDTH-1:0]       mac_acc_in,
  input  logic [2*DATA_WIDTH-1:0]       mac_acc_out
);

  localparam int AW = acc_width(DATA_WIDTH);

  seq_state_e           state;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 first;
  logic [AW-1:0]        res_q;
  logic                 cmd_fire;
  logic                 op_fire;

  // cmd_ready is masked by reset so every output except mac_rst reads 0 while held
  assign cmd_ready = rst && (state == IDLE);
  assign op_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign mac_rst   = (state == IDLE) || (state == DONE);
  assign res_data  = res_q;
  assign cmd_fire  = cmd_ready && cmd_valid;
  assign op_fire   = op_ready && op_valid;

  // The MAC has no enable: bubbles feed zero operands and recirculate the accumulator
  always_comb begin
    mac_a      = op_fire ? op_a : '0;
    mac_b      = op_fire ? op_b : '0;
    mac_acc_in = ((state == ACCUM && !(op_fire && first)) || state == DRAIN) ? mac_acc_out : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      first     <= 1'b0;
      res_q     <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_fire) begin
          if (cmd_len == '0) begin
            res_q <= '0;
            state <= DONE;
          end else begin
            remaining <= cmd_len;
            first     <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: if (op_fire) begin
          first     <= 1'b0;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN: begin
          res_q <= mac_acc_out;
          state <= DONE;
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: scoreboard bench for mac_seq_ctrl with a behavioural MAC beside it
module tb_mac_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [7:0]         cmd_len = '0;
  logic               op_valid = 1'b0;
  logic               op_ready;
  logic signed [15:0] op_a = '0;
  logic signed [15:0] op_b = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [31:0]        res_data;
  logic               busy;
  logic               mac_rst;
  logic signed [15:0] mac_a;
  logic signed [15:0] mac_b;
  logic [31:0]        mac_acc_in;
  logic [31:0]        mac_acc_out;
  logic signed [31:0] prod;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mac_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .mac_rst(mac_rst), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out)
  );

  always #5 clk = ~clk;

  assign prod = mac_a * mac_b;
  always_ff @(posedge clk) mac_acc_out <= mac_rst ? 32'd0 : mac_acc_in + prod;

  task automatic do_cmd(input int len);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_wait cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_op(input int a, input int b);
    int n = 0;
    while (!op_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL op_wait op_ready=%b required 1", op_ready); end
    op_valid = 1'b1;
    op_a     = 16'(a);
    op_b     = 16'(b);
    @(negedge clk);
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
  endtask

  task automatic get_res(input string name);
    int n = 0;
    logic [31:0] e;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (res_valid !== 1'b1 || res_data !== e) begin
      errors++;
      $display("FAIL %s res_valid=%b res_data=%h required %h", name, res_valid, res_data, e);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, op_ready, res_valid, busy, mac_rst} !== 5'b00001 || res_data !== 0 ||
        mac_a !== 0 || mac_b !== 0 || mac_acc_in !== 0) begin
      errors++;
      $display("FAIL reset_outputs cr=%b or=%b rv=%b busy=%b mrst=%b rd=%h required 0 0 0 0 1 0",
               cmd_ready, op_ready, res_valid, busy, mac_rst, res_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_basic();
    int a[3] = '{1, 3, 5};
    int b[3] = '{2, 4, 6};
    logic [31:0] e = 0;
    for (int i = 0; i < 3; i++) e += 32'(a[i] * b[i]);
    exp_q.push_back(e);
    do_cmd(3);
    for (int i = 0; i < 3; i++) do_op(a[i], b[i]);
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_drain res_valid=%b required 0", res_valid); end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_latency res_valid=%b required 1", res_valid); end
    get_res("basic_len3");
  endtask

  task automatic test_zero_len();
    exp_q.push_back(32'd0);
    do_cmd(0);
    checks++;
    if (res_valid !== 1'b1 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len res_valid=%b op_ready=%b required 1 0", res_valid, op_ready);
    end
    get_res("zero_len");
    checks++;
    if (op_ready !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_after op_ready=%b cmd_ready=%b required 0 1", op_ready, cmd_ready);
    end
  endtask

  task automatic test_bubbles();
    int a[4] = '{2, -1, 10, -5};
    int b[4] = '{3, 7, 10, -5};
    logic [31:0] e = 0;
    logic [31:0] held;
    for (int i = 0; i < 4; i++) e += 32'(a[i] * b[i]);
    exp_q.push_back(e);
    do_cmd(4);
    for (int i = 0; i < 4; i++) begin
      do_op(a[i], b[i]);
      if (i < 3) begin
        held = mac_acc_out;
        repeat (2) @(negedge clk);
        checks++;
        if (mac_acc_out !== held) begin
          errors++;
          $display("FAIL bubble_hold beat%0d acc=%h required %h", i, mac_acc_out, held);
        end
      end
    end
    get_res("bubbles_len4");
  endtask

  task automatic test_wrap_backpressure();
    logic [31:0] e = 0;
    for (int i = 0; i < 2; i++) e += 32'(-32768 * -32768);
    exp_q.push_back(e);
    do_cmd(2);
    do_op(-32768, -32768);
    do_op(-32768, -32768);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2);
      cmd_len   = 8'd3;
      checks++;
      if (res_valid !== 1'b1 || res_data !== e || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc%0d rv=%b rd=%h cr=%b required 1 %h 0", i, res_valid, res_data, cmd_ready, e);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    get_res("wrap_len2");
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_cmd busy=%b cmd_ready=%b required 0 1", busy, cmd_ready);
    end
  endtask

  task automatic test_abort();
    exp_q.push_back(32'd49);
    do_cmd(5);
    do_op(100, 100);
    do_op(3, 3);
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, op_ready, res_valid, busy, mac_rst} !== 5'b00001 || res_data !== 0 ||
        mac_a !== 0 || mac_acc_in !== 0) begin
      errors++;
      $display("FAIL abort_outputs cr=%b or=%b rv=%b busy=%b mrst=%b rd=%h required 0 0 0 0 1 0",
               cmd_ready, op_ready, res_valid, busy, mac_rst, res_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_cmd(1);
    do_op(7, 7);
    get_res("after_abort");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd81);
    do_cmd(2);
    do_op(1, 1);
    do_op(1, 1);
    get_res("b2b_first");
    do_cmd(1);
    do_op(9, 9);
    get_res("b2b_second");
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left size=%0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_bubbles();
    test_wrap_backpressure();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
